// File: rtl/led_pulse_stretcher_if.sv
// Event/LED signal bundle for led_pulse_stretcher.
// The master drives event ticks; the slave (the stretcher) drives the LED and status outputs.
interface led_pulse_stretcher_if #(
    parameter int QDEPTH_W = 3
);
    logic                i_pulse;
    logic                o_led;
    logic                o_busy;
    logic [QDEPTH_W-1:0] o_pending;
    logic                o_overflow;

    modport master (
        output i_pulse,
        input  o_led,
        input  o_busy,
        input  o_pending,
        input  o_overflow
    );

    modport slave (
        input  i_pulse,
        output o_led,
        output o_busy,
        output o_pending,
        output o_overflow
    );
endinterface

// File: rtl/led_pulse_stretcher.sv
// Stretches one-clock event ticks into visible LED ON windows, each followed by an OFF gap.
// Optional macro STRETCH_RETRIGGER_EN: a tick during ON restarts the window instead of queueing.
module led_pulse_stretcher #(
    parameter int CLK_DIV  = 100,
    parameter int ON_US    = 50000,
    parameter int GAP_US   = 50000,
    parameter int QDEPTH_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pulse_stretcher_if.slave bus
);
    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int DUR_MAX = (ON_US > GAP_US) ? ON_US : GAP_US;
    localparam int DUR_W   = $clog2(DUR_MAX + 1);

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [DUR_W-1:0]    ON_LAST    = DUR_W'(ON_US - 1);
    localparam logic [DUR_W-1:0]    GAP_LAST   = DUR_W'(GAP_US - 1);
    localparam logic [QDEPTH_W-1:0] Q_FULL     = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } stateType;

    stateType            r_state;
    stateType            w_nextState;
    logic [PRESC_W-1:0]  r_presc;
    logic [DUR_W-1:0]    r_dur;
    logic [QDEPTH_W-1:0] r_pending;
    logic                r_overflow;
    logic                r_led;
    logic                r_busy;

    logic w_usTick;
    logic w_onDone;
    logic w_gapDone;
    logic w_wantStart;
    logic w_retrig;
    logic w_consume;
    logic w_enq;
    logic w_deq;
    logic w_clearCnt;
    logic w_ledNext;
    logic w_busyNext;

    assign w_usTick    = (r_presc == PRESC_LAST);
    assign w_onDone    = w_usTick && (r_dur == ON_LAST);
    assign w_gapDone   = w_usTick && (r_dur == GAP_LAST);
    assign w_wantStart = bus.i_pulse || (r_pending != '0);

`ifdef STRETCH_RETRIGGER_EN
    assign w_retrig = (r_state == ST_ON) && bus.i_pulse;
`else
    assign w_retrig = 1'b0;
`endif

    // A window starts from IDLE or at the end of a gap; the live tick wins over the queue.
    assign w_consume = w_wantStart &&
                       ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_gapDone));
    assign w_deq     = w_consume && !bus.i_pulse;
    assign w_enq     = bus.i_pulse && !w_consume && !w_retrig;

    // Counters restart on every state change so window lengths are exact in clocks.
    assign w_clearCnt = (w_nextState != r_state) || w_retrig || (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_wantStart) w_nextState = ST_ON;
            ST_ON:   if (!w_retrig && w_onDone) w_nextState = ST_GAP;
            ST_GAP:  if (w_gapDone) w_nextState = w_wantStart ? ST_ON : ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ledNext  = (w_nextState == ST_ON);
        w_busyNext = (w_nextState != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_led  <= w_ledNext;
            r_busy <= w_busyNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_dur   <= '0;
        end else if (w_clearCnt) begin
            r_presc <= '0;
            r_dur   <= '0;
        end else if (w_usTick) begin
            r_presc <= '0;
            r_dur   <= r_dur + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // enq and deq are mutually exclusive: deq only happens when no tick is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else if (w_enq) begin
            if (r_pending == Q_FULL) begin
                r_overflow <= 1'b1;
            end else begin
                r_pending <= r_pending + 1'b1;
            end
        end else if (w_deq) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    assign bus.o_led      = r_led;
    assign bus.o_busy     = r_busy;
    assign bus.o_pending  = r_pending;
    assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher (CLK_DIV=4, ON_US=3, GAP_US=2, QDEPTH_W=2).
// An "event at cycle k" holds i_pulse high after edge k, so it is captured by edge k+1.
module tb_led_pulse_stretcher;
    localparam int CLK_DIV  = 4;
    localparam int ON_US    = 3;
    localparam int GAP_US   = 2;
    localparam int QDEPTH_W = 2;
    localparam int ON_CYC   = ON_US * CLK_DIV;
    localparam int GAP_CYC  = GAP_US * CLK_DIV;
    localparam int QMAX     = (1 << QDEPTH_W) - 1;
`ifdef STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;
    int   cyc     = 0;
    bit   modelOn = 1'b0;

    always #5 clk = ~clk;

    led_pulse_stretcher_if #(.QDEPTH_W(QDEPTH_W)) bus ();

    led_pulse_stretcher #(
        .CLK_DIV (CLK_DIV),
        .ON_US   (ON_US),
        .GAP_US  (GAP_US),
        .QDEPTH_W(QDEPTH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Model: phase 0 idle, 1 lit, 2 gap; mRem counts clocks left in the current phase.
    int   mPhase = 0;
    int   mRem   = 0;
    int   mQ     = 0;
    bit   mOvf   = 1'b0;
    logic mP;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase = 0;
            mRem   = 0;
            mQ     = 0;
            mOvf   = 1'b0;
        end else begin
            mP = bus.i_pulse;
            case (mPhase)
                0: begin
                    if (mP || mQ > 0) begin
                        if (!mP) mQ--;
                        mPhase = 1;
                        mRem   = ON_CYC;
                    end
                end
                1: begin
                    if (RETRIG && mP) begin
                        mRem = ON_CYC;
                    end else begin
                        if (mP) begin
                            if (mQ == QMAX) mOvf = 1'b1;
                            else mQ++;
                        end
                        mRem--;
                        if (mRem == 0) begin
                            mPhase = 2;
                            mRem   = GAP_CYC;
                        end
                    end
                end
                default: begin
                    mRem--;
                    if (mRem == 0) begin
                        if (mP || mQ > 0) begin
                            if (!mP) mQ--;
                            mPhase = 1;
                            mRem   = ON_CYC;
                        end else begin
                            mPhase = 0;
                        end
                    end else if (mP) begin
                        if (mQ == QMAX) mOvf = 1'b1;
                        else mQ++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && modelOn) begin
            checkOutput("model led", int'(bus.o_led), int'(mPhase == 1));
            checkOutput("model busy", int'(bus.o_busy), int'(mPhase != 0));
            checkOutput("model pending", int'(bus.o_pending), mQ);
            checkOutput("model overflow", int'(bus.o_overflow), int'(mOvf));
        end
    end

    task automatic applyStimulus(input logic p);
        bus.i_pulse = p;
        @(posedge clk);
        #1;
        cyc++;
        bus.i_pulse = 1'b0;
    endtask

    task automatic runTo(input int n);
        while (cyc < n) applyStimulus(1'b0);
    endtask

    task automatic doReset();
        bus.i_pulse = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_pulse = 1'b0;
        #3;
        checkOutput("reset led", int'(bus.o_led), 0);
        checkOutput("reset busy", int'(bus.o_busy), 0);
        checkOutput("reset pending", int'(bus.o_pending), 0);
        checkOutput("reset overflow", int'(bus.o_overflow), 0);
        doReset();
        modelOn = 1'b1;

        $display("[TB] single event");
        checkOutput("single led c0", int'(bus.o_led), 0);
        applyStimulus(1'b1);
        checkOutput("single led c1", int'(bus.o_led), 1);
        checkOutput("single busy c1", int'(bus.o_busy), 1);
        runTo(12);
        checkOutput("single led c12", int'(bus.o_led), 1);
        runTo(13);
        checkOutput("single led c13", int'(bus.o_led), 0);
        checkOutput("single busy c13", int'(bus.o_busy), 1);
        runTo(20);
        checkOutput("single busy c20", int'(bus.o_busy), 1);
        runTo(21);
        checkOutput("single busy c21", int'(bus.o_busy), 0);
        runTo(24);

`ifndef STRETCH_RETRIGGER_EN
        $display("[TB] three back-to-back events");
        doReset();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("burst pending c2", int'(bus.o_pending), 1);
        applyStimulus(1'b1);
        checkOutput("burst pending c3", int'(bus.o_pending), 2);
        runTo(20);
        checkOutput("burst led c20", int'(bus.o_led), 0);
        checkOutput("burst pending c20", int'(bus.o_pending), 2);
        runTo(21);
        checkOutput("burst led c21", int'(bus.o_led), 1);
        checkOutput("burst pending c21", int'(bus.o_pending), 1);
        runTo(40);
        checkOutput("burst led c40", int'(bus.o_led), 0);
        runTo(41);
        checkOutput("burst led c41", int'(bus.o_led), 1);
        checkOutput("burst pending c41", int'(bus.o_pending), 0);
        runTo(61);
        checkOutput("burst busy c61", int'(bus.o_busy), 0);

        $display("[TB] queue saturation");
        doReset();
        for (int k = 0; k < 8; k++) applyStimulus(k % 2 == 0);
        checkOutput("sat pending c8", int'(bus.o_pending), 3);
        checkOutput("sat overflow c8", int'(bus.o_overflow), 0);
        applyStimulus(1'b1);
        checkOutput("sat pending c9", int'(bus.o_pending), 3);
        checkOutput("sat overflow c9", int'(bus.o_overflow), 1);
        runTo(85);
        checkOutput("sat overflow c85", int'(bus.o_overflow), 1);
        checkOutput("sat busy c85", int'(bus.o_busy), 0);
        checkOutput("sat pending c85", int'(bus.o_pending), 0);

        $display("[TB] event on final gap edge");
        doReset();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("gapedge pending c2", int'(bus.o_pending), 1);
        runTo(20);
        applyStimulus(1'b1);
        checkOutput("gapedge led c21", int'(bus.o_led), 1);
        checkOutput("gapedge pending c21", int'(bus.o_pending), 1);
        checkOutput("gapedge overflow c21", int'(bus.o_overflow), 0);
        runTo(41);
        checkOutput("gapedge led c41", int'(bus.o_led), 1);
        checkOutput("gapedge pending c41", int'(bus.o_pending), 0);
        runTo(65);
`else
        $display("[TB] retrigger during ON");
        doReset();
        applyStimulus(1'b1);
        runTo(6);
        applyStimulus(1'b1);
        checkOutput("retrig led c7", int'(bus.o_led), 1);
        checkOutput("retrig pending c7", int'(bus.o_pending), 0);
        runTo(18);
        checkOutput("retrig led c18", int'(bus.o_led), 1);
        runTo(19);
        checkOutput("retrig led c19", int'(bus.o_led), 0);
        checkOutput("retrig busy c19", int'(bus.o_busy), 1);
        checkOutput("retrig pending c19", int'(bus.o_pending), 0);
        runTo(27);
        checkOutput("retrig busy c27", int'(bus.o_busy), 0);
`endif

        $display("[TB] asynchronous reset mid-window");
        doReset();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        runTo(5);
        checkOutput("async led before rst", int'(bus.o_led), 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async led", int'(bus.o_led), 0);
        checkOutput("async busy", int'(bus.o_busy), 0);
        checkOutput("async pending", int'(bus.o_pending), 0);
        checkOutput("async overflow", int'(bus.o_overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("async queue dropped", int'(bus.o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
